// File: rtl/keypad_debounce.sv
// keypad_debounce: 3-column keypad scanner with frame-level debounce.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_row    row lines, active-high, bit0 = top row
//   key_col    one-hot column drive (001 left, 010 middle, 100 right)
//   key_valid  one-cycle pulse per debounced press
//   key_code   code of the last accepted key (1-9, 0, 10 = '*', 11 = '#')
//   key_held   high while the accepted key is considered held
module keypad_debounce #(
  parameter int unsigned SCAN_DIV       = 12500,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {COL1 = 3'b001, COL2 = 3'b010, COL3 = 3'b100} col_t;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} db_t;

  col_t            col_q, col_d;
  logic [DW-1:0]   dwell_q;
  logic [7:0]      snap_q;
  logic            sample_c;
  logic            frame_done_c;
  logic [11:0]     frame_c;

  assign sample_c     = (dwell_q == DWELL_LAST);
  assign frame_done_c = sample_c && (col_q == COL3);
  // Full frame: the COL3 rows are taken live on the completing edge.
  assign frame_c      = {key_row, snap_q};
  assign key_col      = col_q;

  // Scan state register, dwell counter and per-column row snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= COL1;
      dwell_q <= '0;
      snap_q  <= '0;
    end else begin
      col_q   <= col_d;
      dwell_q <= sample_c ? '0 : dwell_q + DW'(1);
      if (sample_c) begin
        case (col_q)
          COL1:    snap_q[3:0] <= key_row;
          COL2:    snap_q[7:4] <= key_row;
          default: ;
        endcase
      end
    end
  end

  // Column rotation; advances after the last dwell cycle of each column.
  always_comb begin
    col_d = col_q;
    if (sample_c) begin
      case (col_q)
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL1;
      endcase
    end
  end

  // Frame classification: number of set bits and index of the (last) set bit.
  logic [3:0] ones_c;
  logic [3:0] idx_c;
  logic [3:0] code_c;
  logic       empty_c;
  logic       single_c;

  always_comb begin
    ones_c = '0;
    idx_c  = '0;
    for (int i = 0; i < 12; i++) begin
      if (frame_c[i]) begin
        ones_c = ones_c + 4'd1;
        idx_c  = 4'(i);
      end
    end
  end

  assign empty_c  = (ones_c == 4'd0);
  assign single_c = (ones_c == 4'd1);

  // Bit index is col*4 + row.
  always_comb begin
    case (idx_c)
      4'd0:    code_c = 4'd1;
      4'd1:    code_c = 4'd4;
      4'd2:    code_c = 4'd7;
      4'd3:    code_c = 4'd10;
      4'd4:    code_c = 4'd2;
      4'd5:    code_c = 4'd5;
      4'd6:    code_c = 4'd8;
      4'd7:    code_c = 4'd0;
      4'd8:    code_c = 4'd3;
      4'd9:    code_c = 4'd6;
      4'd10:   code_c = 4'd9;
      default: code_c = 4'd11;
    endcase
  end

  db_t           db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [3:0]    cand_q, cand_d;
  logic          valid_d, held_d;
  logic [3:0]    code_d;

  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Debounce state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q      <= IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_valid <= valid_d;
      key_code  <= code_d;
      key_held  <= held_d;
    end
  end

  // Debounce next-state logic, evaluated only on frame completion.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    valid_d = 1'b0;
    code_d  = key_code;
    held_d  = key_held;
    if (frame_done_c) begin
      case (db_q)
        IDLE: begin
          if (single_c) begin
            cand_d = code_c;
            cnt_d  = CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
              valid_d = 1'b1;
              code_d  = code_c;
              db_d    = HELD;
            end else begin
              db_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (single_c && (code_c == cand_q)) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_MAX) begin
              valid_d = 1'b1;
              code_d  = cand_q;
              db_d    = HELD;
            end
          end else if (single_c) begin
            cand_d = code_c;
            cnt_d  = CNT_ONE;
          end else begin
            db_d = IDLE;
          end
        end
        HELD: begin
          if (empty_c) begin
            cnt_d = CNT_ONE;
            db_d  = (CNT_MAX == CNT_ONE) ? IDLE : REL_CHK;
          end
        end
        default: begin
          if (empty_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_MAX) db_d = IDLE;
          end else begin
            db_d = HELD;
          end
        end
      endcase
      // A release still under check keeps the key reported as held.
      held_d = (db_d == HELD) || (db_d == REL_CHK);
    end
  end

endmodule
